rv_instr_encoder: RTL and testbench
===================================

// Module: rv_instr_encoder
// PURPOSE
//  Streaming RV32I instruction encoder. Inverse of the main control decoder: packs instruction
//  fields (class, registers, funct3, alt bit, immediate) into 32-bit machine words.
//  Emits each word with a sequential instruction-memory address, for boot/program loading into imem.
//  One registered pipeline stage; valid/ready handshake on both sides.
// PARAMETERS
//  ADDR_W     32           width of out_addr
//  BASE_ADDR  32'h0000_0000  address of first word after start
//  CNT_W      16           width of word counter
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  start      in   1       pulse: clear counter/error, address:=BASE_ADDR, go RUN
//  in_valid   in   1       input descriptor valid
//  in_ready   out  1       encoder can accept descriptor
//  in_class   in   3       0 R,1 I_ALU,2 LOAD,3 STORE,4 BRANCH,5 LUI,6 AUIPC,7 JAL
//  in_rd/in_rs1/in_rs2  in 5 each  register indices
//  in_funct3  in   3       funct3 field (ignored for LUI/AUIPC/JAL)
//  in_alt     in   1       instr[30] for R-type and SRAI/SRLI selection (I_ALU funct3 001/101 only)
//  in_imm     in   32      signed byte offset / value; U-type uses in_imm[31:12]
//  out_valid  out  1       out_instr/out_addr valid
//  out_ready  in   1       consumer accepts word
//  out_instr  out  32      encoded instruction
//  out_addr   out  ADDR_W  imem byte address of out_instr
//  count      out  CNT_W   words accepted by consumer since start
//  busy       out  1       state==RUN
//  err        out  1       sticky immediate-range error (0 when macro absent)
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, out_instr=0, out_addr=BASE_ADDR, count=0, err=0, in_ready=0.
//  FSM: IDLE -start-> RUN; RUN -range error-> HALT; HALT -start-> RUN; start in any state -> RUN.
//  start clears out_valid (pending word dropped), count, err; start has priority over a same-cycle input.
//  in_ready = (state==RUN) && (!out_valid || out_ready). Input transfer on in_valid&&in_ready.
//  Latency 1: word registered on transfer, out_valid next cycle; full throughput with out_ready=1.
//  Output held stable while out_valid && !out_ready.
//  On out_valid&&out_ready: count+=1 (wraps at 2^CNT_W); out_addr+=4 (wraps mod 2^ADDR_W).
//  Simultaneous output accept and new input: new word loaded, out_valid stays 1.
//  Opcodes: 0110011,0010011,0000011,0100011,1100011,0110111,0010111,1101111.
//  Formats: R {alt<<5,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; shift-I {0,alt,5'b0,imm[4:0],...};
//   S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op};
//   U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
//  Unused fields of a format are zero. Bits outside a format's immediate are ignored (truncated).
// CONFIGURATION
//  IMM_RANGE_CHECK_EN defined: on transfer, check I/LOAD/S in [-2048,2047], shamt 0..31,
//   B even in [-4096,4094], J even in [-2^20,2^20-2], U low 12 bits zero. Violation: descriptor consumed,
//   no word emitted, err=1, state->HALT (in_ready=0) until start.
//  Undefined: no check, silent truncation, err tied 0, HALT unreachable.
// STRUCTURE
//  Package rv_isa_pkg: opcode localparams, class codes, format enum (R,I,SHI,S,B,U,J).
//  Sub-module rv_imm_pack (combinational: class+imm -> immediate bits at their instruction positions,
//   plus range_ok); top holds FSM, output register, address/count counters.
// TESTING
//  ADD x3,x1,x2 (class0,rd3,rs1 1,rs2 2,f3 0) after start -> 0x002081B3 at addr BASE_ADDR.
//  ADDI x1,x0,5 then SW x2,8(x1) back-to-back, out_ready=1 -> 0x00500093 @0, 0x0020A423 @4, count=2.
//  BEQ x0,x0,-4 -> 0xFE000EE3; SRAI x5,x5,3 (alt=1) -> 0x4032D293.
//  out_ready=0 for 3 cycles with word pending -> out_instr/out_addr stable, in_ready=0, count unchanged.
//  ADDI x1,x0,2048: with IMM_RANGE_CHECK_EN -> err=1, no out_valid, in_ready=0 until start;
//   without -> 0x80000093.
//  rst asserted mid-stream / start with word pending -> out_valid=0, count=0, out_addr=BASE_ADDR.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants, descriptor class codes, instruction formats and encoder FSM states.
package rv_isa_pkg;

  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
  localparam logic [6:0] OpcodeLoad   = 7'b0000011;
  localparam logic [6:0] OpcodeStore  = 7'b0100011;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;
  localparam logic [6:0] OpcodeLui    = 7'b0110111;
  localparam logic [6:0] OpcodeAuipc  = 7'b0010111;
  localparam logic [6:0] OpcodeJal    = 7'b1101111;

  typedef enum logic [2:0] {
    ClsR      = 3'd0,
    ClsIAlu   = 3'd1,
    ClsLoad   = 3'd2,
    ClsStore  = 3'd3,
    ClsBranch = 3'd4,
    ClsLui    = 3'd5,
    ClsAuipc  = 3'd6,
    ClsJal    = 3'd7
  } instr_class_e;

  typedef enum logic [2:0] {FmtR, FmtI, FmtShi, FmtS, FmtB, FmtU, FmtJ} instr_fmt_e;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} enc_state_e;

  function automatic instr_fmt_e class_fmt(input logic [2:0] cls, input logic [2:0] funct3);
    case (instr_class_e'(cls))
      ClsR:             return FmtR;
      ClsIAlu:          return (funct3[1:0] == 2'b01) ? FmtShi : FmtI;
      ClsLoad:          return FmtI;
      ClsStore:         return FmtS;
      ClsBranch:        return FmtB;
      ClsLui, ClsAuipc: return FmtU;
      default:          return FmtJ;
    endcase
  endfunction

  function automatic logic [6:0] class_opcode(input logic [2:0] cls);
    case (instr_class_e'(cls))
      ClsR:      return OpcodeOp;
      ClsIAlu:   return OpcodeOpImm;
      ClsLoad:   return OpcodeLoad;
      ClsStore:  return OpcodeStore;
      ClsBranch: return OpcodeBranch;
      ClsLui:    return OpcodeLui;
      ClsAuipc:  return OpcodeAuipc;
      default:   return OpcodeJal;
    endcase
  endfunction

endpackage

// File: rtl/rv_imm_pack.sv
// Places a descriptor immediate at its instruction bit positions for the class format.
// Range checking is compiled in with IMM_RANGE_CHECK_EN; otherwise range_ok_o is tied high.
module rv_imm_pack
  import rv_isa_pkg::*;
(
  input  logic [2:0]  cls_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] imm_i,
  output instr_fmt_e  fmt_o,
  output logic [31:0] imm_bits_o,
  output logic        range_ok_o
);

  always_comb begin
    fmt_o      = class_fmt(cls_i, funct3_i);
    imm_bits_o = '0;
    case (fmt_o)
      FmtI:   imm_bits_o[31:20] = imm_i[11:0];
      FmtShi: imm_bits_o[24:20] = imm_i[4:0];
      FmtS: begin
        imm_bits_o[31:25] = imm_i[11:5];
        imm_bits_o[11:7]  = imm_i[4:0];
      end
      FmtB: begin
        imm_bits_o[31]    = imm_i[12];
        imm_bits_o[30:25] = imm_i[10:5];
        imm_bits_o[11:8]  = imm_i[4:1];
        imm_bits_o[7]     = imm_i[11];
      end
      FmtU:   imm_bits_o[31:12] = imm_i[31:12];
      FmtJ:   imm_bits_o[31:12] = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12]};
      default: ;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Signed ranges are checked as "upper bits are a sign extension of the field MSB".
  always_comb begin
    range_ok_o = 1'b1;
    case (fmt_o)
      FmtI, FmtS: range_ok_o = (imm_i[31:11] == {21{imm_i[11]}});
      FmtShi:     range_ok_o = (imm_i[31:5] == 27'd0);
      FmtB:       range_ok_o = !imm_i[0] && (imm_i[31:12] == {20{imm_i[12]}});
      FmtJ:       range_ok_o = !imm_i[0] && (imm_i[31:20] == {12{imm_i[20]}});
      FmtU:       range_ok_o = (imm_i[11:0] == 12'd0);
      default:    range_ok_o = 1'b1;
    endcase
  end
`else
  assign range_ok_o = 1'b1;
`endif

endmodule

// File: rtl/rv_instr_encoder.sv
// Streaming RV32I encoder: descriptor in, registered machine word plus imem address out.
// Define IMM_RANGE_CHECK_EN to enable immediate range checking with sticky err and HALT.
module rv_instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              err
);

  enc_state_e        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  instr_fmt_e  fmt;
  logic [31:0] imm_bits;
  logic        range_ok;
  logic [31:0] fixed_bits;
  logic [6:0]  opcode;
  logic        xfer, accept;

  rv_imm_pack u_imm_pack (
    .cls_i      (in_class),
    .funct3_i   (in_funct3),
    .imm_i      (in_imm),
    .fmt_o      (fmt),
    .imm_bits_o (imm_bits),
    .range_ok_o (range_ok)
  );

  assign opcode = class_opcode(in_class);

  // Non-immediate fields; the immediate is OR-ed in from rv_imm_pack.
  always_comb begin
    fixed_bits = '0;
    case (fmt)
      FmtR:       fixed_bits = {1'b0, in_alt, 5'd0, in_rs2, in_rs1, in_funct3, in_rd, opcode};
      FmtI:       fixed_bits = {12'd0, in_rs1, in_funct3, in_rd, opcode};
      FmtShi:     fixed_bits = {1'b0, in_alt, 10'd0, in_rs1, in_funct3, in_rd, opcode};
      FmtS, FmtB: fixed_bits = {7'd0, in_rs2, in_rs1, in_funct3, 5'd0, opcode};
      default:    fixed_bits = {20'd0, in_rd, opcode};
    endcase
  end

  assign in_ready = (state_q == StRun) && (!out_valid_q || out_ready);
  assign xfer     = in_valid && in_ready && !start;
  assign accept   = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_d       = err_q;
    if (start) begin
      state_d     = StRun;
      out_valid_d = 1'b0;
      addr_d      = BASE_ADDR;
      count_d     = '0;
      err_d       = 1'b0;
    end else begin
      if (accept) begin
        out_valid_d = 1'b0;
        count_d     = count_q + CNT_W'(1);
        addr_d      = addr_q + ADDR_W'(4);
      end
      if (xfer) begin
        if (range_ok) begin
          out_valid_d = 1'b1;
          instr_d     = fixed_bits | imm_bits;
        end else begin
          err_d   = 1'b1;
          state_d = StHalt;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      addr_q      <= BASE_ADDR;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign count     = count_q;
  assign busy      = (state_q == StRun);
  assign err       = err_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Scoreboarded bench for rv_instr_encoder: directed ISA vectors plus randomized descriptors.
module tb_rv_instr_encoder;

  localparam int unsigned AddrW = 32;
  localparam int unsigned CntW  = 16;
  localparam logic [31:0] Base  = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, in_ready, in_alt;
  logic [2:0]       in_class, in_funct3;
  logic [4:0]       in_rd, in_rs1, in_rs2;
  logic [31:0]      in_imm, out_instr;
  logic             out_valid, out_ready, busy, err;
  logic [AddrW-1:0] out_addr;
  logic [CntW-1:0]  count;

  always #5 clk = ~clk;

  rv_instr_encoder #(.ADDR_W(AddrW), .BASE_ADDR(Base), .CNT_W(CntW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .count(count),
    .busy(busy), .err(err)
  );

  typedef struct packed {logic [31:0] instr; logic [31:0] addr;} exp_t;
  exp_t        exp_q[$];
  int          n_cmp = 0, n_err = 0;
  int unsigned emit_idx = 0, acc_cnt = 0;
  bit          mon_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference encoding written straight from the RV32I field layouts.
  function automatic logic [31:0] ref_encode(input logic [2:0] cls, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
      input logic [31:0] imm);
    case (cls)
      3'd0: return {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
      3'd1: if (f3 == 3'd1 || f3 == 3'd5)
              return {1'b0, alt, 5'b0, imm[4:0], rs1, f3, rd, 7'b0010011};
            else return {imm[11:0], rs1, f3, rd, 7'b0010011};
      3'd2: return {imm[11:0], rs1, f3, rd, 7'b0000011};
      3'd3: return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      3'd4: return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      3'd5: return {imm[31:12], rd, 7'b0110111};
      3'd6: return {imm[31:12], rd, 7'b0010111};
      default: return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endcase
  endfunction

  function automatic bit ref_ok(input logic [2:0] cls, input logic [2:0] f3,
      input logic [31:0] imm);
`ifdef IMM_RANGE_CHECK_EN
    int s;
    s = int'(imm);
    case (cls)
      3'd1: if (f3 == 3'd1 || f3 == 3'd5) return imm <= 32'd31;
            else return s >= -2048 && s <= 2047;
      3'd2, 3'd3: return s >= -2048 && s <= 2047;
      3'd4: return (s % 2 == 0) && s >= -4096 && s <= 4094;
      3'd5, 3'd6: return (imm % 4096) == 0;
      3'd7: return (s % 2 == 0) && s >= -1048576 && s <= 1048574;
      default: return 1'b1;
    endcase
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] rand_imm(input logic [2:0] cls, input logic [2:0] f3);
    case (cls)
      3'd1: if (f3 == 3'd1 || f3 == 3'd5) return 32'($urandom_range(0, 31));
            else return 32'(int'($urandom_range(0, 4095)) - 2048);
      3'd2, 3'd3: return 32'(int'($urandom_range(0, 4095)) - 2048);
      3'd4: return 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
      3'd5, 3'd6: return $urandom & 32'hFFFF_F000;
      3'd7: return 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
      default: return $urandom;
    endcase
  endfunction

  // Called at posedge+1; holds the descriptor until it transfers, then returns at posedge+1.
  task automatic send(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic alt, input logic [31:0] imm,
      input logic [31:0] want, input bit ok);
    bit got = 0;
    in_valid = 1'b1; in_class = cls; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_alt = alt; in_imm = imm;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (in_ready) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end else begin
      if (ok) begin
        exp_q.push_back('{instr: want, addr: Base + 32'(4 * emit_idx)});
        emit_idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.delete();
    emit_idx = 0;
    acc_cnt  = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops on every output handshake, checks count and stall stability.
  bit          stall_prev = 0;
  logic [31:0] stall_instr, stall_addr;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("count", 64'(count), 64'(acc_cnt[CntW-1:0]));
      if (stall_prev && !start) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_instr", 64'(out_instr), 64'(stall_instr));
        check("stall_addr", 64'(out_addr), 64'(stall_addr));
      end
      stall_prev  = out_valid && !out_ready && !start;
      stall_instr = out_instr;
      stall_addr  = out_addr;
      if (out_valid && out_ready && !start) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_word: got %08h @%08h, expected none", out_instr, out_addr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_instr", 64'(out_instr), 64'(e.instr));
          check("out_addr", 64'(out_addr), 64'(e.addr));
        end
        acc_cnt++;
      end
    end else stall_prev = 0;
  end

  initial begin
    logic [31:0] snap_instr, snap_addr;
    logic [CntW-1:0] snap_cnt;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_alt = 1'b0;
    in_imm = '0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'(Base));
    check("rst_count", 64'(count), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1;
    do_start();
    check("start_busy", 64'(busy), 64'd1);

    // Directed vectors, back to back with out_ready=1.
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 32'h002081B3, 1);
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 32'h00500093, 1);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, 32'h0020A423, 1);
    send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, -32'sd4, 32'hFE000EE3, 1);
    send(3'd1, 5'd5, 5'd5, 5'd0, 3'd5, 1'b1, 32'd3, 32'h4032D293, 1);
    drain();
    check("count_after_directed", 64'(count), 64'd5);

    // Consumer stall holds the word.
    out_ready = 1'b0;
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 32'h00500093, 1);
    @(negedge clk);
    snap_instr = out_instr; snap_addr = out_addr; snap_cnt = count;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_count", 64'(count), 64'(snap_cnt));
      check("stall_hold_instr", 64'(out_instr), 64'(snap_instr));
      check("stall_hold_addr", 64'(out_addr), 64'(snap_addr));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Out-of-range ADDI immediate.
`ifdef IMM_RANGE_CHECK_EN
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 32'h0, 0);
    @(negedge clk);
    check("range_err", 64'(err), 64'd1);
    check("range_no_valid", 64'(out_valid), 64'd0);
    check("range_in_ready", 64'(in_ready), 64'd0);
    check("range_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    do_start();
    check("restart_err", 64'(err), 64'd0);
    check("restart_in_ready", 64'(in_ready), 64'd1);
`else
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 32'h80000093, 1);
    drain();
`endif

    // Randomized descriptors with a randomly stalling consumer.
    begin
      bit done = 0;
      fork
        begin
          for (int i = 0; i < 300; i++) begin
            logic [2:0] c, f;
            logic [4:0] a, b, d;
            logic       al;
            logic [31:0] im;
            c = 3'($urandom_range(0, 7)); f = 3'($urandom_range(0, 7));
            a = 5'($urandom_range(0, 31)); b = 5'($urandom_range(0, 31));
            d = 5'($urandom_range(0, 31)); al = 1'($urandom_range(0, 1));
            im = rand_imm(c, f);
            send(c, d, a, b, f, al, im, ref_encode(c, d, a, b, f, al, im), ref_ok(c, f, im));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          end
          done = 1;
        end
        begin
          while (!done) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
          end
        end
      join
    end
    out_ready = 1'b1;
    drain();

    // start with a word pending drops it.
    out_ready = 1'b0;
    send(3'd5, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCDE000, 32'hABCDE3B7, 1);
    @(negedge clk);
    check("pend_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    do_start();
    @(negedge clk);
    check("start_drop_valid", 64'(out_valid), 64'd0);
    check("start_drop_count", 64'(count), 64'd0);
    check("start_drop_addr", 64'(out_addr), 64'(Base));
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 32'h001000EF, 1);
    send(3'd6, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 32'h12345117, 1);
    drain();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    send(3'd2, 5'd4, 5'd3, 5'd0, 3'd2, 1'b0, -32'sd16, 32'hFF01A203, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_addr", 64'(out_addr), 64'(Base));
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete(); emit_idx = 0; acc_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    do_start();
    send(3'd0, 5'd10, 5'd11, 5'd12, 3'd7, 1'b0, 32'd0, 32'h00C5F533, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
